// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One radix-2 step per cycle: shift-add for MUL*, restoring shift-subtract
// for DIV*/REM*. Divide-by-zero and signed overflow finish without iterating.
// Start/Busy/Done handshake; Result holds until the next accepted Start.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] Result,
  output logic            Busy,
  output logic            Done
);

  // Iteration counter width, derived from XLEN.
  localparam int CNTW = $clog2(XLEN) + 1;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [2:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_opnd;    // multiplicand (MUL*) or divisor (DIV*/REM*)
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;      // product low half + multiplier / quotient + dividend
  logic [CNTW-1:0]   r_cnt;
  logic [XLEN-1:0]   r_result;

  // ---- operand decode at Start ----
  logic              w_signed_a;
  logic              w_signed_b;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_result;

  assign w_signed_a = (Funct3 == F_MULH) || (Funct3 == F_MULHSU) ||
                      (Funct3 == F_DIV)  || (Funct3 == F_REM);
  assign w_signed_b = (Funct3 == F_MULH) || (Funct3 == F_DIV) || (Funct3 == F_REM);
  assign w_sign_a   = SrcA[XLEN-1] & w_signed_a;
  assign w_sign_b   = SrcB[XLEN-1] & w_signed_b;
  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign w_mag_a    = w_sign_a ? -SrcA : SrcA;
  assign w_mag_b    = w_sign_b ? -SrcB : SrcB;

  assign w_div_zero = Funct3[2] && (SrcB == '0);
  assign w_div_ovf  = ((Funct3 == F_DIV) || (Funct3 == F_REM)) &&
                      (SrcA == MOST_NEG) && (SrcB == '1);
  assign w_special  = w_div_zero || w_div_ovf;
  // Funct3[1] distinguishes REM/REMU from DIV/DIVU.
  assign w_special_result = w_div_zero ? (Funct3[1] ? SrcA : '1)
                                       : (Funct3[1] ? '0   : SrcA);

  // ---- one multiply step: conditional add, then shift right ----
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_mul_hi_next;
  logic [XLEN-1:0]   w_mul_lo_next;

  assign w_mul_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi_next = w_mul_sum[XLEN:1];
  assign w_mul_lo_next = {w_mul_sum[0], r_lo[XLEN-1:1]};

  // ---- one restoring divide step: shift left, trial subtract ----
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_fits;
  logic [XLEN-1:0]   w_div_hi_next;
  logic [XLEN-1:0]   w_div_lo_next;

  assign w_div_shift   = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff    = w_div_shift - {1'b0, r_opnd};
  assign w_div_fits    = ~w_div_diff[XLEN];
  assign w_div_hi_next = w_div_fits ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
  assign w_div_lo_next = {r_lo[XLEN-2:0], w_div_fits};

  // ---- sign fix-up of the final step's values ----
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  assign w_prod     = {w_mul_hi_next, w_mul_lo_next};
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -w_div_lo_next : w_div_lo_next;
  assign w_rem_fix  = r_sign_a ? -w_div_hi_next : w_div_hi_next;

  // Select the architectural result for the latched operation.
  always_comb begin
    w_final = '0;
    case (r_op)
      F_MUL:                    w_final = w_prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:            w_final = w_quo_fix;
      default:                  w_final = w_rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_next unwritten,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_next = w_special ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CNTW'(1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and register the fixed-up result.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset along with the FSM so a discarded
    // operation leaves no stale operands or result behind.
    if (reset) begin
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op     <= Funct3;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_hi     <= '0;
            if (w_special) begin
              r_result <= w_special_result;
            end else begin
              r_opnd <= Funct3[2] ? w_mag_b : w_mag_a;
              r_lo   <= Funct3[2] ? w_mag_a : w_mag_b;
              r_cnt  <= CNTW'(XLEN);
            end
          end
        end
        S_CALC: begin
          r_hi  <= r_op[2] ? w_div_hi_next : w_mul_hi_next;
          r_lo  <= r_op[2] ? w_div_lo_next : w_mul_lo_next;
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign Result = r_result;
  assign Busy   = (r_state != S_IDLE);
  assign Done   = (r_state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed vectors for muldiv_unit (XLEN=32),
// plus hand-written sequences for held Start and reset during an operation.
module tb_muldiv_unit;

  localparam int XLEN     = 32;
  localparam int LAT_FULL = XLEN + 1;
  localparam int LAT_SPEC = 1;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            reset;
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [XLEN-1:0] Result;
  logic            Busy;
  logic            Done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string           name;
    logic [2:0]      f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Result (Result),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    vec_t v;
    v.name = name; v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one operation, follow it to Done (bounded), then sample the idle cycle.
  task automatic do_op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       output int lat, output logic [XLEN-1:0] res,
                       output bit busy_ok, output bit idle_ok, output logic [XLEN-1:0] held);
    @(negedge clk);
    Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    @(posedge clk);
    lat = -1; res = '0; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      Start = 1'b0;
      SrcA = ~a; SrcB = ~b;
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        lat = k;
        res = Result;
        break;
      end
    end
    @(negedge clk);
    idle_ok = !Busy && !Done;
    held    = Result;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int              lat;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] held;
    bit              busy_ok;
    bit              idle_ok;
    bit              done_seen;

    add("MUL 7*-3",         F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL);
    add("MUL min*min low",  F_MUL,    32'h80000000, 32'h80000000, 32'h00000000, LAT_FULL);
    add("MULH -1*-1",       F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_FULL);
    add("MULHSU -1*max",    F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_FULL);
    add("MULHU max*max",    F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_FULL);
    add("MULH min*min",     F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_FULL);
    add("MULH min*maxpos",  F_MULH,   32'h80000000, 32'h7FFFFFFF, 32'hC0000000, LAT_FULL);
    add("MULHSU min*2",     F_MULHSU, 32'h80000000, 32'd2,        32'hFFFFFFFF, LAT_FULL);
    add("DIV -7/2",         F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_FULL);
    add("REM -7/2",         F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_FULL);
    add("DIV -7/-2",        F_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        LAT_FULL);
    add("REM 7/-2",         F_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        LAT_FULL);
    add("DIVU 100/7",       F_DIVU,   32'd100,      32'd7,        32'd14,       LAT_FULL);
    add("REMU 100/7",       F_REMU,   32'd100,      32'd7,        32'd2,        LAT_FULL);
    add("DIV min/1",        F_DIV,    32'h80000000, 32'd1,        32'h80000000, LAT_FULL);
    add("DIVU max/3",       F_DIVU,   32'hFFFFFFFF, 32'd3,        32'h55555555, LAT_FULL);
    add("DIV 5/0",          F_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPEC);
    add("DIVU 5/0",         F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPEC);
    add("REM 5/0",          F_REM,    32'd5,        32'd0,        32'd5,        LAT_SPEC);
    add("REMU 5/0",         F_REMU,   32'd5,        32'd0,        32'd5,        LAT_SPEC);
    add("DIV min/-1",       F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPEC);
    add("REM min/-1",       F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPEC);

    // Reset state.
    reset = 1'b1; Start = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset Busy",   64'(Busy),   64'd0);
    check("reset Done",   64'(Done),   64'd0);
    check("reset Result", 64'(Result), 64'd0);
    reset = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, res, busy_ok, idle_ok, held);
      check({vecs[i].name, " result"},  64'(res),     64'(vecs[i].exp));
      check({vecs[i].name, " latency"}, 64'(lat),     64'(vecs[i].lat));
      check({vecs[i].name, " busy"},    64'(busy_ok), 64'd1);
      check({vecs[i].name, " idle"},    64'(idle_ok), 64'd1);
      check({vecs[i].name, " held"},    64'(held),    64'(vecs[i].exp));
    end

    // Start held high throughout with operands changing every cycle.
    @(negedge clk);
    Start = 1'b1; Funct3 = F_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    lat = -1; res = '0; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      Funct3 = F_MUL; SrcA = 32'(k * 3 + 1); SrcB = 32'(k);
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        lat = k;
        res = Result;
        break;
      end
    end
    check("held-start result",  64'(res),     64'd14);
    check("held-start latency", 64'(lat),     64'(LAT_FULL));
    check("held-start busy",    64'(busy_ok), 64'd1);
    Funct3 = F_DIVU; SrcA = 32'd9; SrcB = 32'd0;
    @(negedge clk);
    check("held-start idle Busy",   64'(Busy),   64'd0);
    check("held-start idle Result", 64'(Result), 64'd14);
    @(negedge clk);
    Start = 1'b0;
    check("held-start next Done",   64'(Done),   64'd1);
    check("held-start next Result", 64'(Result), 64'hFFFFFFFF);
    @(negedge clk);
    check("held-start next idle",   64'(Busy),   64'd0);

    // Reset during a DIVU discards the operation.
    @(negedge clk);
    Start = 1'b1; Funct3 = F_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      Start = 1'b0;
      if (Done) done_seen = 1'b1;
      if (k == 10) reset = 1'b1;
    end
    @(negedge clk);
    check("mid-reset no early Done", 64'(done_seen), 64'd0);
    check("mid-reset Busy",          64'(Busy),      64'd0);
    check("mid-reset Done",          64'(Done),      64'd0);
    check("mid-reset Result",        64'(Result),    64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset stays idle",   64'(Busy),      64'd0);
    do_op(F_DIVU, 32'd9, 32'd3, lat, res, busy_ok, idle_ok, held);
    check("post-reset DIVU result",  64'(res),     64'd3);
    check("post-reset DIVU latency", 64'(lat),     64'(LAT_FULL));
    check("post-reset DIVU busy",    64'(busy_ok), 64'd1);
    check("post-reset DIVU idle",    64'(idle_ok), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
